// File: rtl/calculator_pkg.sv
// Shared types and constants for the calculator: ops, error flag, LED states, 7-segment codes.
package calculator_pkg;

  typedef enum logic [1:0] {
    OpPlus,
    OpSub,
    OpMul,
    OpDiv
  } op_e;

  typedef enum logic {
    ErrNone    = 1'b0,
    ErrDivZero = 1'b1
  } err_e;

  // LED pins are active-low: a 0 marks the lit LED.
  localparam logic [2:0] LedIdle   = 3'b110;
  localparam logic [2:0] LedKeyA   = 3'b101;
  localparam logic [2:0] LedKeyB   = 3'b011;
  localparam logic [2:0] LedResult = 3'b110;

  localparam logic [7:0] SegZero   = 8'hC0;
  localparam logic [7:0] SegMinus  = 8'hBF;
  localparam logic [7:0] SegErr    = 8'h86;
  localparam logic [7:0] SegDpMask = 8'h7F;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 8'hC0;
      4'd1:    seg_digit = 8'hF9;
      4'd2:    seg_digit = 8'hA4;
      4'd3:    seg_digit = 8'hB0;
      4'd4:    seg_digit = 8'h99;
      4'd5:    seg_digit = 8'h92;
      4'd6:    seg_digit = 8'h82;
      4'd7:    seg_digit = 8'hF8;
      4'd8:    seg_digit = 8'h80;
      4'd9:    seg_digit = 8'h90;
      default: seg_digit = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Signed binary to 4-digit decimal 7-segment scanner. Anodes and segments are registered
// together and only reload at a digit-slot boundary.
module seg7_scan
  import calculator_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 50000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic signed [11:0] value_i,
  input  logic               dp_en_i,
  input  logic               err_i,
  output logic [3:0]         anodes_o,
  output logic [7:0]         segments_o
);

  localparam int unsigned CntW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      dig_q, dig_d, dig_nx;
  logic [3:0]      an_q, an_d;
  logic [7:0]      seg_q, seg_d, seg_next;
  logic [11:0]     mag;
  logic [3:0]      bcd [4];

  assign dig_nx = dig_q + 2'd1;

  always_comb begin
    mag    = value_i[11] ? 12'(-value_i) : 12'(value_i);
    bcd[0] = 4'(mag % 12'd10);
    bcd[1] = 4'((mag / 12'd10) % 12'd10);
    bcd[2] = 4'((mag / 12'd100) % 12'd10);
    bcd[3] = 4'((mag / 12'd1000) % 12'd10);
  end

  // Segment pattern for the digit that becomes active at the next slot boundary.
  always_comb begin
    seg_next = seg_digit(bcd[dig_nx]);
    if (err_i) begin
      seg_next = (dig_nx == 2'd0) ? SegErr : SegZero;
    end else if (value_i[11] && dig_nx == 2'd3) begin
      seg_next = SegMinus;
    end else if (dp_en_i && dig_nx == 2'd2) begin
      seg_next = seg_next & SegDpMask;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    dig_d = dig_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (cnt_q == CntW'(SCAN_CYCLES - 1)) begin
      cnt_d = '0;
      dig_d = dig_nx;
      an_d  = ~(4'b0001 << dig_nx);
      seg_d = seg_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      dig_q <= 2'd0;
      an_q  <= 4'b1110;
      seg_q <= SegZero;
    end else begin
      cnt_q <= cnt_d;
      dig_q <= dig_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign anodes_o   = an_q;
  assign segments_o = seg_q;

endmodule

// File: rtl/calculator_core.sv
// Two-operand 4-bit decimal calculator: input conditioning, operand registers, ALU, LEDs.
// Optional button debounce is compiled in with CALCULATOR_DEBOUNCE_EN.
module calculator_core
  import calculator_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 50000,
  parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_number,
  input  logic [3:0] arif,
  input  logic [1:0] key,
  output logic [3:0] anodes,
  output logic [7:0] segments,
  output logic [2:0] led
);

`ifdef CALCULATOR_DEBOUNCE_EN
  localparam bit DebounceEn = 1'b1;
`else
  localparam bit DebounceEn = 1'b0;
`endif

  logic [9:0]  sync1_q, sync2_q;
  logic [3:0]  live;
  logic [5:0]  btn_sync, btn_cond, btn_prev_q, btn_press;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic [11:0] res_q, res_d, alu_res, a_ext, b_ext;
  op_e         op_q, op_d, op_sel;
  err_e        err_q, err_d, alu_err;
  logic        active_q, active_d, show;
  logic [2:0]  led_q, led_d;
  logic signed [11:0] disp_val;

  // Synchronizers idle high so released buttons and a zero operand are seen out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      btn_prev_q <= '0;
    end else begin
      sync1_q    <= {key, arif, in_number};
      sync2_q    <= sync1_q;
      btn_prev_q <= btn_cond;
    end
  end

  assign live     = ~sync2_q[3:0];
  assign btn_sync = ~sync2_q[9:4];

  if (DebounceEn && DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic [5:0]     stable_q, stable_d;
    logic [DbW-1:0] cnt_q [6];
    logic [DbW-1:0] cnt_d [6];

    always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 6; i++) begin
        cnt_d[i] = '0;
        if (btn_sync[i] != stable_q[i]) begin
          if (cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = btn_sync[i];
          else cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_q <= '0;
        for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
      end else begin
        stable_q <= stable_d;
        cnt_q    <= cnt_d;
      end
    end

    assign btn_cond = stable_q;
  end else begin : g_bypass
    assign btn_cond = btn_sync;
  end

  assign btn_press = btn_cond & ~btn_prev_q;

  always_comb begin
    if (btn_press[0])      op_sel = OpPlus;
    else if (btn_press[1]) op_sel = OpSub;
    else if (btn_press[2]) op_sel = OpMul;
    else                   op_sel = OpDiv;

    a_ext   = {8'd0, a_q};
    b_ext   = {8'd0, b_q};
    alu_res = '0;
    alu_err = ErrNone;
    case (op_sel)
      OpPlus: alu_res = a_ext + b_ext;
      OpSub:  alu_res = a_ext - b_ext;
      OpMul:  alu_res = a_ext * b_ext;
      OpDiv: begin
        if (b_q == 4'd0) alu_err = ErrDivZero;
        else alu_res = (a_ext * 12'd100) / b_ext;
      end
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_d     = op_q;
    err_d    = err_q;
    active_d = active_q;
    led_d    = led_q;
    if (btn_press[4]) begin
      a_d   = live;
      led_d = LedKeyA;
    end
    if (btn_press[5]) begin
      b_d   = live;
      led_d = LedKeyB;
    end
    if (|btn_press[3:0]) begin
      res_d    = alu_res;
      op_d     = op_sel;
      err_d    = alu_err;
      active_d = 1'b1;
      led_d    = LedResult;
    end else if (active_q && !btn_cond[op_q]) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= OpPlus;
      err_q    <= ErrNone;
      active_q <= 1'b0;
      led_q    <= LedIdle;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      op_q     <= op_d;
      err_q    <= err_d;
      active_q <= active_d;
      led_q    <= led_d;
    end
  end

  // The result is only shown while the button that produced it is still held.
  assign show     = active_q && btn_cond[op_q];
  assign disp_val = show ? res_q : {8'd0, live};

  seg7_scan #(
    .SCAN_CYCLES(SCAN_CYCLES)
  ) u_scan (
    .clk_i      (clk),
    .rst_i      (rst),
    .value_i    (disp_val),
    .dp_en_i    (show && op_q == OpDiv && err_q == ErrNone),
    .err_i      (show && err_q == ErrDivZero),
    .anodes_o   (anodes),
    .segments_o (segments)
  );

  assign led = led_q;

endmodule

// File: tb/tb_calculator_core.sv
// Directed bench for calculator_core plus a full operand sweep against a decimal model.
module tb_calculator_core;

  localparam int unsigned SCAN = 2;
  localparam int unsigned DB   = 4;
  localparam int          HOLD = 12;

  localparam logic [7:0] SEG_LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_number;
  logic [3:0] arif;
  logic [1:0] key;
  logic [3:0] anodes;
  logic [7:0] segments;
  logic [2:0] led;

  int n_checks = 0;
  int n_errors = 0;

  calculator_core #(
    .SCAN_CYCLES    (SCAN),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_number (in_number),
    .arif      (arif),
    .key       (key),
    .anodes    (anodes),
    .segments  (segments),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sw(input int v);
    @(negedge clk);
    in_number = ~4'(v);
  endtask

  task automatic press_key(input logic [1:0] which);
    @(negedge clk);
    key = ~which;
    repeat (HOLD) @(negedge clk);
    key = 2'b11;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic enter(input int a, input int b);
    set_sw(a);
    press_key(2'b01);
    set_sw(b);
    press_key(2'b10);
  endtask

  task automatic hold_ops(input logic [3:0] mask);
    @(negedge clk);
    arif = ~mask;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic release_ops();
    @(negedge clk);
    arif = 4'hF;
    repeat (HOLD) @(negedge clk);
  endtask

  // Frame layout: [31:24] = digit under anode 0111 ... [7:0] = digit under anode 1110.
  task automatic read_frame(output logic [31:0] f);
    f = '0;
    repeat (SCAN + 3) @(posedge clk);
    for (int c = 0; c < 4 * SCAN; c++) begin
      @(negedge clk);
      case (anodes)
        4'b1110: f[7:0]   = segments;
        4'b1101: f[15:8]  = segments;
        4'b1011: f[23:16] = segments;
        4'b0111: f[31:24] = segments;
        default: f = '0;
      endcase
    end
  endtask

  function automatic logic [31:0] model(input int a, input int b, input int op);
    int          r;
    int          m;
    logic [31:0] f;
    if (op == 3 && b == 0) return 32'hC0C0C086;
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a * b;
      default: r = (100 * a) / b;
    endcase
    m = (r < 0) ? -r : r;
    f = {SEG_LUT[(m / 1000) % 10], SEG_LUT[(m / 100) % 10], SEG_LUT[(m / 10) % 10],
         SEG_LUT[m % 10]};
    if (r < 0) f[31:24] = 8'hBF;
    if (op == 3) f[23] = 1'b0;
    return f;
  endfunction

  task automatic check_scan();
    logic [3:0] an_prev;
    logic [7:0] seg_prev;
    int         run;
    int         glitch;
    int         edges;
    @(negedge clk);
    an_prev  = anodes;
    seg_prev = segments;
    run      = 1;
    glitch   = 0;
    edges    = 0;
    for (int c = 0; c < 12 * SCAN && edges < 6; c++) begin
      @(negedge clk);
      if (anodes != an_prev) begin
        if (edges > 0) check("scan_period", run, SCAN);
        check("scan_rotate", anodes, {an_prev[2:0], an_prev[3]});
        check("scan_onehot", $countones(anodes), 3);
        edges++;
        run = 1;
      end else begin
        run++;
        if (segments != seg_prev) glitch++;
      end
      an_prev  = anodes;
      seg_prev = segments;
    end
    check("scan_edges", edges, 6);
    check("seg_glitch", glitch, 0);
  endtask

  logic [31:0] frame;
  int          waited;

  initial begin
    rst       = 1'b1;
    in_number = 4'hF;
    arif      = 4'hF;
    key       = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_anodes", anodes, 4'b1110);
    check("rst_led", led, 3'b110);
    check("rst_segments", segments, 8'hC0);
    rst = 1'b0;

    set_sw(7);
    press_key(2'b01);
    check("led_key_a", led, 3'b101);
    set_sw(3);
    press_key(2'b10);
    check("led_key_b", led, 3'b011);
    hold_ops(4'b0001);
    check("led_op", led, 3'b110);
    read_frame(frame);
    check("add_7_3", frame, 32'hC0C0F9C0);
    release_ops();
    read_frame(frame);
    check("live_after_release", frame, 32'hC0C0C0B0);
    check("led_kept", led, 3'b110);

    enter(2, 15);
    hold_ops(4'b0010);
    read_frame(frame);
    check("sub_2_15", frame, 32'hBFC0F9B0);
    release_ops();

    enter(15, 15);
    hold_ops(4'b0100);
    read_frame(frame);
    check("mul_15_15", frame, 32'hC0A4A492);
    release_ops();

    enter(15, 1);
    hold_ops(4'b1000);
    read_frame(frame);
    check("div_15_1", frame, 32'hF912C0C0);
    release_ops();

    enter(1, 3);
    hold_ops(4'b1000);
    read_frame(frame);
    check("div_1_3", frame, 32'hC040B0B0);
    release_ops();

    enter(1, 0);
    hold_ops(4'b1000);
    read_frame(frame);
    check("div_by_zero", frame, 32'hC0C0C086);
    release_ops();

    set_sw(5);
    press_key(2'b11);
    check("led_both_keys", led, 3'b011);
    hold_ops(4'b1111);
    read_frame(frame);
    check("priority_add_5_5", frame, 32'hC0C0F9C0);
    release_ops();

    check_scan();

    // Async reset in the middle of a scan slot.
    press_key(2'b01);
    waited = 0;
    while (anodes != 4'b1011 && waited < 8 * SCAN) begin
      @(negedge clk);
      waited++;
    end
    check("wait_anode_1011", anodes, 4'b1011);
    #2 rst = 1'b1;
    #1;
    check("midrst_anodes", anodes, 4'b1110);
    check("midrst_led", led, 3'b110);
    @(negedge clk);
    rst = 1'b0;
    hold_ops(4'b0001);
    read_frame(frame);
    check("midrst_operands_cleared", frame, 32'hC0C0C0C0);
    release_ops();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        enter(a, b);
        for (int op = 0; op < 4; op++) begin
          hold_ops(4'b0001 << op);
          read_frame(frame);
          check($sformatf("sweep_a%0d_b%0d_op%0d", a, b, op), frame, model(a, b, op));
          release_ops();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
